// File: rtl/csub_seq24.sv
// Nibble-serial 24-bit subtractor (a - b - bin) sharing one 4-bit carry-lookahead slice.
// Define ABS_DIFF_EN to add a nibble-serial negate pass that returns |a - b - bin|.
module csub_seq24 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] a,
  input  logic [23:0] b,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] diff,
  output logic        bout,
  output logic        neg
);

`ifdef ABS_DIFF_EN
  typedef enum logic [1:0] {IDLE, RUN, NEG, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t      state, state_nx;
  logic [23:0] a_r, b_r, res;
  logic [2:0]  k;
  logic [4:0]  idx;
  logic        carry, bout_r, in_ready_r, out_valid_r;
  logic [3:0]  nib_x, nib_y;
  logic [4:0]  sum;
  logic        accept, last;

  assign idx    = {k, 2'b00};
  assign accept = (state == IDLE) && in_valid && in_ready_r;
  assign last   = (k == 3'd5);

  // Shared slice: subtract pass adds ~b; negate pass adds 0 to ~res with carry seeded to 1.
  always_comb begin
    nib_x = a_r[idx +: 4];
    nib_y = ~b_r[idx +: 4];
`ifdef ABS_DIFF_EN
    if (state == NEG) begin
      nib_x = ~res[idx +: 4];
      nib_y = 4'h0;
    end
`endif
    sum = {1'b0, nib_x} + {1'b0, nib_y} + {4'b0000, carry};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = RUN;
      RUN: if (last) begin
`ifdef ABS_DIFF_EN
        state_nx = sum[4] ? DONE : NEG;
`else
        state_nx = DONE;
`endif
      end
`ifdef ABS_DIFF_EN
      NEG:  if (last) state_nx = DONE;
`endif
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r         <= '0;
      b_r         <= '0;
      res         <= '0;
      k           <= '0;
      carry       <= 1'b0;
      bout_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r        <= a;
            b_r        <= b;
            k          <= '0;
            carry      <= ~bin;
            in_ready_r <= 1'b0;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        RUN: begin
          res[idx +: 4] <= sum[3:0];
          carry         <= sum[4];
          k             <= k + 3'd1;
          if (last) begin
            bout_r <= ~sum[4];
            k      <= '0;
`ifdef ABS_DIFF_EN
            if (!sum[4]) carry <= 1'b1;
            else         out_valid_r <= 1'b1;
`else
            out_valid_r <= 1'b1;
`endif
          end
        end
`ifdef ABS_DIFF_EN
        NEG: begin
          res[idx +: 4] <= sum[3:0];
          carry         <= sum[4];
          k             <= k + 3'd1;
          if (last) begin
            k           <= '0;
            out_valid_r <= 1'b1;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign diff      = res;
  assign bout      = bout_r;
  assign neg       = bout_r;

endmodule
